async_fifo: RTL and testbench

- Parameterised FIFO buffer with a write port and a read port, both in a single clock domain.
- Decouples a producer from a consumer: data goes in on the write port and comes out in order on the read port.
- Provides full/empty flow control.
- The port set matches the dual-domain FIFO interface, so it can later be swapped for a CDC variant without changing the surrounding logic.

---
 rtl/async_fifo.sv | 113 +++++++++++
 tb/tb_async_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - single-clock FIFO with dual-domain FIFO port set.
// Optional fill-level outputs enabled by defining ASYNC_FIFO_LEVEL_EN.
module async_fifo #(
    parameter int BITS     = 32,
    parameter int SIZE     = 16,
    parameter int AF_LEVEL = SIZE - 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    p_write_en,
    input  logic [BITS-1:0]         p_write_data,
    output logic                    p_write_full,
    input  logic                    p_read_en,
    output logic [BITS-1:0]         p_read_data,
    output logic                    p_read_empty
`ifdef ASYNC_FIFO_LEVEL_EN
    ,
    output logic [$clog2(SIZE):0]   p_level,
    output logic                    p_write_almost_full,
    output logic                    p_read_almost_empty
`endif
);

    localparam int AW = $clog2(SIZE);

    if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_bad_size
        $error("async_fifo: SIZE must be a power of two and at least 2");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > SIZE) begin : g_bad_af_level
        $error("async_fifo: AF_LEVEL must lie in 0..SIZE");
    end

    logic [BITS-1:0] mem_q [SIZE];

    logic [AW:0]     wptr_q, wptr_d;
    logic [AW:0]     rptr_q, rptr_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic [BITS-1:0] rdata_q;
    logic            wr_acc, rd_acc;

    assign wr_acc = p_write_en && !full_q;
    assign rd_acc = p_read_en && !empty_q;

    // Flags are derived from next-state pointers so they are exact, never lagging.
    always_comb begin
        wptr_d  = wptr_q + {{AW{1'b0}}, wr_acc};
        rptr_d  = rptr_q + {{AW{1'b0}}, rd_acc};
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[AW-1:0] == rptr_d[AW-1:0]) && (wptr_d[AW] != rptr_d[AW]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            rdata_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            if (rd_acc) begin
                rdata_q <= mem_q[rptr_q[AW-1:0]];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q[AW-1:0]] <= p_write_data;
        end
    end

    assign p_write_full = full_q;
    assign p_read_empty = empty_q;
    assign p_read_data  = rdata_q;

`ifdef ASYNC_FIFO_LEVEL_EN
    localparam logic [AW:0] AF_LVL = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL = (AW + 1)'(1);

    logic [AW:0] level_q, level_d;
    logic        af_q, af_d;
    logic        ae_q, ae_d;

    always_comb begin
        level_d = wptr_d - rptr_d;
        af_d    = (level_d >= AF_LVL);
        ae_d    = (level_d <= AE_LVL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            level_q <= level_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    assign p_level             = level_q;
    assign p_write_almost_full = af_q;
    assign p_read_almost_empty = ae_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - scoreboard bench for async_fifo (default and ASYNC_FIFO_LEVEL_EN builds).
module tb_async_fifo;

    localparam int BITS = 32;
    localparam int SIZE = 16;
    localparam int AFL  = SIZE - 2;

    logic            clk;
    logic            rstn;
    logic            p_write_en;
    logic [BITS-1:0] p_write_data;
    logic            p_write_full;
    logic            p_read_en;
    logic [BITS-1:0] p_read_data;
    logic            p_read_empty;
`ifdef ASYNC_FIFO_LEVEL_EN
    logic [4:0]      p_level;
    logic            p_write_almost_full;
    logic            p_read_almost_empty;
`endif

    async_fifo #(.BITS(BITS), .SIZE(SIZE)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .p_write_en   (p_write_en),
        .p_write_data (p_write_data),
        .p_write_full (p_write_full),
        .p_read_en    (p_read_en),
        .p_read_data  (p_read_data),
        .p_read_empty (p_read_empty)
`ifdef ASYNC_FIFO_LEVEL_EN
        ,
        .p_level             (p_level),
        .p_write_almost_full (p_write_almost_full),
        .p_read_almost_empty (p_read_almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [BITS-1:0] mq[$];     // contents the FIFO should hold
    logic [BITS-1:0] exp_q[$];  // read data the DUT owes us

    task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each handshake the DUT accepts must yield the next scoreboard word.
    always @(posedge clk) begin
        if (rstn && p_read_en && !p_read_empty) begin
            #1;
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", p_read_data, 'x);
            end else begin
                chk("rd_data", p_read_data, exp_q.pop_front());
            end
        end
    end

    task automatic check_flags();
        chk("empty", {31'd0, p_read_empty}, {31'd0, mq.size() == 0});
        chk("full", {31'd0, p_write_full}, {31'd0, mq.size() == SIZE});
`ifdef ASYNC_FIFO_LEVEL_EN
        chk("level", {27'd0, p_level}, BITS'(mq.size()));
        chk("almost_full", {31'd0, p_write_almost_full}, {31'd0, mq.size() >= AFL});
        chk("almost_empty", {31'd0, p_read_almost_empty}, {31'd0, mq.size() <= 1});
`endif
    endtask

    task automatic cycle(input logic we, input logic [BITS-1:0] wd, input logic re);
        bit wacc, racc;
        @(negedge clk);
        p_write_en   = we;
        p_write_data = wd;
        p_read_en    = re;
        @(posedge clk);
        wacc = we && (mq.size() < SIZE);
        racc = re && (mq.size() > 0);
        if (racc) exp_q.push_back(mq.pop_front());
        if (wacc) mq.push_back(wd);
        #1;
        check_flags();
    endtask

    task automatic drain();
        while (mq.size() > 0) cycle(1'b0, '0, 1'b1);
    endtask

    int wi, rd_cnt, pre;

    initial begin
        rstn = 1'b0;
        p_write_en = 1'b0;
        p_write_data = '0;
        p_read_en = 1'b0;
        repeat (2) @(negedge clk);
        check_flags();
        chk("reset_rdata", p_read_data, '0);
        rstn = 1'b1;

        // Fill with 0..F, then an ignored write while full.
        for (int i = 0; i < SIZE; i++) cycle(1'b1, BITS'(i), 1'b0);
        chk("full_after_16", {31'd0, p_write_full}, 32'd1);
        cycle(1'b1, 32'hDEAD, 1'b0);

        // Drain 0..F in order; a read while empty must hold the last word.
        for (int i = 0; i < SIZE; i++) cycle(1'b0, '0, 1'b1);
        chk("empty_after_16", {31'd0, p_read_empty}, 32'd1);
        cycle(1'b0, '0, 1'b1);
        chk("hold_on_empty", p_read_data, 32'hF);

        // Fill to 8, then simultaneous read/write for 20 cycles.
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h20 + BITS'(i), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h28 + BITS'(i), 1'b1);
        drain();

        // Empty with both enables: only the write lands, no fall-through.
        cycle(1'b1, 32'h77, 1'b1);
        chk("no_fallthrough", p_read_data, 32'h3B);
        drain();

        // 40 words under random enables.
        wi = 0;
        rd_cnt = 0;
        for (int c = 0; c < 800 && rd_cnt < 40; c++) begin
            logic we, re;
            we  = (wi < 40) && ($urandom_range(0, 1) == 1);
            re  = ($urandom_range(0, 2) != 0);
            pre = mq.size();
            cycle(we, 32'h100 + BITS'(wi), re);
            if (we && pre < SIZE) wi++;
            if (re && pre > 0) rd_cnt++;
        end
        chk("stream_reads", BITS'(rd_cnt), 32'd40);

        // Full with both enables high: read only, full drops.
        for (int i = 0; i < SIZE; i++) cycle(1'b1, 32'h200 + BITS'(i), 1'b0);
        cycle(1'b1, 32'hBEEF, 1'b1);
        chk("full_dropped", {31'd0, p_write_full}, 32'd0);
        drain();

        // Asynchronous reset with 5 entries stored.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h300 + BITS'(i), 1'b0);
        @(negedge clk);
        p_write_en = 1'b0;
        p_read_en  = 1'b0;
        #3 rstn = 1'b0;
        mq.delete();
        #1;
        chk("rst_empty", {31'd0, p_read_empty}, 32'd1);
        chk("rst_full", {31'd0, p_write_full}, 32'd0);
        chk("rst_rdata", p_read_data, '0);
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b1, 32'hA1, 1'b0);
        cycle(1'b1, 32'hA2, 1'b0);
        drain();
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("scoreboard_drained", BITS'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
